// File: rtl/rename_regfile_mp_pkg.sv
// Shared definitions for the multi-port rename register file.
// Provides the geometry constants, the tag layout {valid, rob_pos}, the x0 constant
// and small helpers to pack a tag and test its valid bit.
// Optional build macro (used by the lookup ports): RF_COMMIT_BYPASS_EN.
package rename_regfile_mp_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int ROB_DEPTH = 16;
  localparam int ISSUE_W   = 2;
  localparam int COMMIT_W  = 2;
  localparam int REG_POS_W = 5;
  localparam int ROB_POS_W = $clog2(ROB_DEPTH);
  localparam int TAG_W     = ROB_POS_W + 1;
  localparam int NLOOKUP   = ISSUE_W * 2;
  localparam int BUSY_W    = $clog2(NREG + 1);

  typedef logic [XLEN-1:0]      xlen_t;
  typedef logic [TAG_W-1:0]     tag_t;
  typedef logic [ROB_POS_W-1:0] rob_pos_t;
  typedef logic [REG_POS_W-1:0] reg_pos_t;

  localparam reg_pos_t REG_X0   = '0;
  localparam tag_t     TAG_NONE = '0;

  // Tag layout: MSB is the valid (pending) bit, low bits are the ROB position.
  function automatic tag_t tag_pack(input rob_pos_t pos);
    return {1'b1, pos};
  endfunction

  function automatic logic tag_valid(input tag_t t);
    return t[TAG_W-1];
  endfunction

endpackage

// File: rtl/rename_regfile_mp_if.sv
// Bus between dispatch/ROB (master) and the rename register file (slave).
// Carries: rdy stall, ISSUE_W*2 source lookups (addr in, val/tag out), ISSUE_W issue
// slots (en/rd/rob_pos), COMMIT_W commit slots (en/rd/val/rob_pos), flush and busy_cnt.
// All vectors are flat, slot k occupying bits [k*W +: W].
interface rename_regfile_mp_if;
  import rename_regfile_mp_pkg::*;

  logic                          rdy;
  logic [NLOOKUP*REG_POS_W-1:0]  rs_addr;
  logic [NLOOKUP*XLEN-1:0]       rs_val;
  logic [NLOOKUP*TAG_W-1:0]      rs_tag;
  logic [ISSUE_W-1:0]            issue_en;
  logic [ISSUE_W*REG_POS_W-1:0]  issue_rd;
  logic [ISSUE_W*ROB_POS_W-1:0]  issue_rob_pos;
  logic [COMMIT_W-1:0]           commit_en;
  logic [COMMIT_W*REG_POS_W-1:0] commit_rd;
  logic [COMMIT_W*XLEN-1:0]      commit_val;
  logic [COMMIT_W*ROB_POS_W-1:0] commit_rob_pos;
  logic                          flush;
  logic [BUSY_W-1:0]             busy_cnt;

  modport master (
    output rdy, rs_addr, issue_en, issue_rd, issue_rob_pos,
           commit_en, commit_rd, commit_val, commit_rob_pos, flush,
    input  rs_val, rs_tag, busy_cnt
  );

  modport slave (
    input  rdy, rs_addr, issue_en, issue_rd, issue_rob_pos,
           commit_en, commit_rd, commit_val, commit_rob_pos, flush,
    output rs_val, rs_tag, busy_cnt
  );

endinterface

// File: rtl/rename_regfile_mp_rf_lookup_port.sv
// rf_lookup_port: one combinational source-operand lookup.
// Ports: addr (source reg), reg_val/reg_tag (registered entry for addr),
// commit_* (same-cycle commits, only with RF_COMMIT_BYPASS_EN), val/tag (result).
// x0 always reads as value 0 with an invalid tag.
// RF_COMMIT_BYPASS_EN: a commit whose rd and rob_pos match the pending tag is forwarded
// (youngest matching slot wins) and the operand is reported ready.
module rf_lookup_port
  import rename_regfile_mp_pkg::*;
(
  input  reg_pos_t                      addr,
  input  xlen_t                         reg_val,
  input  tag_t                          reg_tag,
`ifdef RF_COMMIT_BYPASS_EN
  input  logic [COMMIT_W-1:0]           commit_en,
  input  logic [COMMIT_W*REG_POS_W-1:0] commit_rd,
  input  logic [COMMIT_W*XLEN-1:0]      commit_val,
  input  logic [COMMIT_W*ROB_POS_W-1:0] commit_rob_pos,
`endif
  output xlen_t                         val,
  output tag_t                          tag
);

  always_comb begin
    val = reg_val;
    tag = reg_tag;
`ifdef RF_COMMIT_BYPASS_EN
    // Ascending scan so the youngest matching slot overrides older ones.
    for (int j = 0; j < COMMIT_W; j++) begin
      if (commit_en[j] && commit_rd[j*REG_POS_W +: REG_POS_W] == addr &&
          reg_tag == tag_pack(commit_rob_pos[j*ROB_POS_W +: ROB_POS_W])) begin
        val = commit_val[j*XLEN +: XLEN];
        tag = TAG_NONE;
      end
    end
`endif
    if (addr == REG_X0) begin
      val = '0;
      tag = TAG_NONE;
    end
  end

endmodule

// File: rtl/rename_regfile_mp.sv
// rename_regfile_mp: multi-port architectural register file with rename tags.
// Ports: clk, rst_n (synchronous, active low), bus (slave modport of rename_regfile_mp_if).
// Holds value and tag arrays; applies commits (slot 0 oldest), then issues (higher
// slot wins), then flush; busy_cnt is the registered count of pending tags.
// Optional build macro: RF_COMMIT_BYPASS_EN (commit-to-lookup forwarding).
module rename_regfile_mp
  import rename_regfile_mp_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  rename_regfile_mp_if.slave bus
);

  logic [NREG-1:0][XLEN-1:0]  val_reg, val_next;
  logic [NREG-1:0][TAG_W-1:0] tag_reg, tag_next;
  logic [BUSY_W-1:0]          busy_reg, busy_next;

  xlen_t lk_val [NLOOKUP];
  tag_t  lk_tag [NLOOKUP];

  generate
    for (genvar gi = 0; gi < NLOOKUP; gi++) begin : g_lookup
      reg_pos_t lk_addr;
      assign lk_addr = bus.rs_addr[gi*REG_POS_W +: REG_POS_W];

      rf_lookup_port u_port (
        .addr           (lk_addr),
        .reg_val        (val_reg[lk_addr]),
        .reg_tag        (tag_reg[lk_addr]),
`ifdef RF_COMMIT_BYPASS_EN
        .commit_en      (bus.commit_en),
        .commit_rd      (bus.commit_rd),
        .commit_val     (bus.commit_val),
        .commit_rob_pos (bus.commit_rob_pos),
`endif
        .val            (lk_val[gi]),
        .tag            (lk_tag[gi])
      );
    end
  endgenerate

  always_comb begin
    bus.rs_val = '0;
    bus.rs_tag = '0;
    for (int k = 0; k < NLOOKUP; k++) begin
      bus.rs_val[k*XLEN +: XLEN]   = lk_val[k];
      bus.rs_tag[k*TAG_W +: TAG_W] = lk_tag[k];
    end
  end

  always_comb begin
    val_next = val_reg;
    tag_next = tag_reg;

    // Commits: values always land (younger slot last); each slot's tag-clear test
    // uses the pre-cycle tag so an older slot may clear what a younger slot misses.
    for (int j = 0; j < COMMIT_W; j++) begin
      if (bus.commit_en[j] && bus.commit_rd[j*REG_POS_W +: REG_POS_W] != REG_X0) begin
        val_next[bus.commit_rd[j*REG_POS_W +: REG_POS_W]] = bus.commit_val[j*XLEN +: XLEN];
        if (tag_reg[bus.commit_rd[j*REG_POS_W +: REG_POS_W]] ==
            tag_pack(bus.commit_rob_pos[j*ROB_POS_W +: ROB_POS_W]))
          tag_next[bus.commit_rd[j*REG_POS_W +: REG_POS_W]] = TAG_NONE;
      end
    end

    // Issues applied after commits so a new rename beats a same-cycle clear.
    for (int i = 0; i < ISSUE_W; i++) begin
      if (!bus.flush && bus.issue_en[i] &&
          bus.issue_rd[i*REG_POS_W +: REG_POS_W] != REG_X0)
        tag_next[bus.issue_rd[i*REG_POS_W +: REG_POS_W]] =
          tag_pack(bus.issue_rob_pos[i*ROB_POS_W +: ROB_POS_W]);
    end

    if (bus.flush)
      tag_next = '0;

    busy_next = '0;
    for (int r = 0; r < NREG; r++)
      busy_next = busy_next + BUSY_W'(tag_valid(tag_next[r]));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_reg  <= '0;
      tag_reg  <= '0;
      busy_reg <= '0;
    end else if (bus.rdy) begin
      val_reg  <= val_next;
      tag_reg  <= tag_next;
      busy_reg <= busy_next;
    end
  end

  assign bus.busy_cnt = busy_reg;

endmodule
